// File: rtl/epidemic_pkg.sv
// Shared encodings and helpers for epidemic agent nodes.
package epidemic_pkg;

  typedef enum logic [1:0] {
    SUS = 2'd0,
    EXP = 2'd1,
    INF = 2'd2,
    REC = 2'd3
  } seirs_state_e;

  typedef enum logic [2:0] {
    CFG_CONN     = 3'd0,
    CFG_THRESH   = 3'd1,
    CFG_LAT      = 3'd2,
    CFG_INFDUR   = 3'd3,
    CFG_IMM      = 3'd4,
    CFG_SEED     = 3'd5,
    CFG_CONN_RST = 3'd6,
    CFG_NOP      = 3'd7
  } cfg_sel_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // One right-shift step of the Galois LFSR.
  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
  endfunction

  // The all-zero state locks the LFSR, so it is replaced by 1.
  function automatic logic [31:0] nz_seed(input logic [31:0] v);
    return (v == '0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with synchronous load and step-gated advance.
module lfsr32_galois
  import epidemic_pkg::*;
#(
  parameter logic [31:0] seedParam = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  input  logic        load,
  input  logic [31:0] loadValue,
  output logic [31:0] value
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  // A load overrides an advance in the same cycle.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = nz_seed(loadValue);
    end else if (advance) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= nz_seed(seedParam);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/seirs_agent.sv
// SEIRS epidemic agent node: programmable phase durations, word-serial
// connectivity load and LFSR-drawn infection attempts.
module seirs_agent
  import epidemic_pkg::*;
#(
  parameter int unsigned NODE_ADDR  = 0,
  parameter int unsigned NUM_AGENTS = 100,
  parameter int unsigned CNT_W      = 8,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  step,
  input  logic [NUM_AGENTS-1:0] neighbourEdges,
  output logic [NUM_AGENTS-1:0] outputEdges,
  input  logic [31:0]           address,
  input  logic                  loadState,
  input  logic [1:0]            initState,
  input  logic                  cfgWrite,
  input  logic [2:0]            cfgSel,
  input  logic [31:0]           cfgData,
  output logic [1:0]            currState
);

  localparam int unsigned NUM_WORDS = (NUM_AGENTS + 31) / 32;
  localparam int unsigned OFF_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int unsigned PAD_W     = NUM_WORDS * 32;

  seirs_state_e          state_q, state_d;
  logic [CNT_W-1:0]      timer_q, timer_d;
  logic [NUM_AGENTS-1:0] edges_q, edges_d;
  logic [NUM_AGENTS-1:0] conn_q, conn_d;
  logic [PAD_W-1:0]      conn_pad;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [31:0]           thresh_q;
  logic [CNT_W-1:0]      lat_q, infdur_q, imm_q;
  logic [CNT_W-1:0]      inf_load;
  logic [31:0]           lfsr_val;
  logic                  addr_hit, cfg_hit, load_hit, draw, exposed;
  cfg_sel_e              cfg_sel;

  assign addr_hit = (address == 32'(NODE_ADDR));
  assign cfg_hit  = cfgWrite && addr_hit;
  assign load_hit = loadState && addr_hit;
  assign cfg_sel  = cfg_sel_e'(cfgSel);
  assign draw     = (lfsr_val < thresh_q);
  assign exposed  = |neighbourEdges;
  assign inf_load = (infdur_q == '0) ? CNT_W'(1) : infdur_q;

  lfsr32_galois #(
    .seedParam(LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (step),
    .load     (cfg_hit && (cfg_sel == CFG_SEED)),
    .loadValue(cfgData),
    .value    (lfsr_val)
  );

  // Connectivity word insertion: widen to whole words so the last partial
  // word can be sliced uniformly, then drop the bits beyond NUM_AGENTS.
  always_comb begin
    conn_pad                   = '0;
    conn_pad[NUM_AGENTS-1:0]   = conn_q;
    conn_d                     = conn_q;
    off_d                      = off_q;
    if (cfg_hit) begin
      case (cfg_sel)
        CFG_CONN: begin
          conn_pad[{off_q, 5'b0} +: 32] = cfgData;
          conn_d = conn_pad[NUM_AGENTS-1:0];
          off_d  = (off_q == OFF_W'(NUM_WORDS - 1)) ? '0 : off_q + OFF_W'(1);
        end
        CFG_CONN_RST: off_d = '0;
        default: ;
      endcase
    end
  end

  // Configuration registers; a concurrent step sees the old values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conn_q   <= '0;
      off_q    <= '0;
      thresh_q <= '0;
      lat_q    <= '0;
      infdur_q <= CNT_W'(1);
      imm_q    <= '0;
    end else begin
      conn_q <= conn_d;
      off_q  <= off_d;
      if (cfg_hit) begin
        case (cfg_sel)
          CFG_THRESH: thresh_q <= cfgData;
          CFG_LAT:    lat_q    <= cfgData[CNT_W-1:0];
          CFG_INFDUR: infdur_q <= cfgData[CNT_W-1:0];
          CFG_IMM:    imm_q    <= cfgData[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  // Model state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SUS;
      timer_q <= '0;
      edges_q <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      edges_q <= edges_d;
    end
  end

  // Next-state logic; a zero timer in EXP/REC (forced load with zero
  // duration) is treated like 1 so the phase is skipped on the next step.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    if (load_hit) begin
      state_d = seirs_state_e'(initState);
      case (seirs_state_e'(initState))
        EXP:     timer_d = lat_q;
        INF:     timer_d = inf_load;
        REC:     timer_d = imm_q;
        default: timer_d = '0;
      endcase
    end else if (step) begin
      case (state_q)
        SUS: begin
          if (exposed && (lat_q != '0)) begin
            state_d = EXP;
            timer_d = lat_q;
          end else if (exposed) begin
            state_d = INF;
            timer_d = inf_load;
          end
        end
        EXP: begin
          if (timer_q <= CNT_W'(1)) begin
            state_d = INF;
            timer_d = inf_load;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        INF: begin
          if (timer_q <= CNT_W'(1)) begin
            state_d = (imm_q != '0) ? REC : SUS;
            timer_d = imm_q;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        REC: begin
          if (timer_q <= CNT_W'(1)) begin
            state_d = SUS;
            timer_d = '0;
          end else begin
            timer_d = timer_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: infection attempts from the pre-transition state, held between steps.
  always_comb begin
    edges_d = edges_q;
    if (load_hit) begin
      edges_d = '0;
    end else if (step) begin
      edges_d = ((state_q == INF) && draw) ? conn_q : '0;
    end
  end

  assign outputEdges = edges_q;
  assign currState   = state_q;

endmodule

// File: doc/seirs_agent.md
Name: seirs_agent

Overview:
- Next-generation epidemic agent node that replaces the two-state SUS/INF agent with a four-state SEIRS model.
- Per-state durations are runtime-programmable.
- Connectivity is loaded word-serially, and a per-node LFSR draws the infection probability.
- One instance per population member. Instances are tiled by the top-level mesh, where each node's outputEdges bit k feeds node k's neighbourEdges bit NODE_ADDR.

Parameters:
NODE_ADDR, 0, node index matched against address for loadState/cfgWrite
NUM_AGENTS, 100, population size = edge vector width
CNT_W, 8, width of duration registers and the dwell timer
LFSR_SEED, 32'h0000_0001, reset value of the infection LFSR; a value of 0 is replaced by 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
step  in  1  epoch advance strobe; all model evolution happens only on step cycles
neighbourEdges  in  NUM_AGENTS  infection attempts from other nodes (OR-reduced)
outputEdges  out  NUM_AGENTS  registered infection attempts toward neighbours
address  in  32  target node for loadState/cfgWrite
loadState  in  1  force state when address==NODE_ADDR
initState  in  2  state to force (0 SUS, 1 EXP, 2 INF, 3 REC)
cfgWrite  in  1  configuration write strobe (address-qualified)
cfgSel  in  3  configuration register select
cfgData  in  32  configuration write data
currState  out  2  current model state

Behaviour:
Reset:
- Asynchronous, active-low.
- state=SUS, timer=0, outputEdges=0, connectivity=0, wordOffset=0, lfsr=LFSR_SEED (or 1 if the seed is 0).
- infThresh=0, latDur=0, infDur=1, immDur=0. These defaults give SIS behaviour with zero infection probability.

Config (applies on clk when cfgWrite && address==NODE_ADDR):
- cfgSel 0: connectivity[wordOffset*32 +: 32] <= cfgData. Bits at or above NUM_AGENTS are discarded. wordOffset increments and wraps to 0 after word ceil(NUM_AGENTS/32)-1.
- cfgSel 1: infThresh <= cfgData.
- cfgSel 2/3/4: latDur/infDur/immDur <= cfgData[CNT_W-1:0].
- cfgSel 5: lfsr <= cfgData, or 1 if cfgData is 0.
- cfgSel 6: wordOffset <= 0.
- cfgSel 7: no effect.
- If cfgWrite and step occur in the same cycle, step uses the pre-write values.

LFSR:
- 32-bit Galois, polynomial 0x80200003.
- Advances only on step cycles (reproducible per epoch).
- draw = (lfsr < infThresh), evaluated on the current value before the advance.

State machine (evaluated on step, no loadState):
- SUS:
  - If |neighbourEdges and latDur!=0: go to EXP, timer <= latDur.
  - If |neighbourEdges and latDur==0: go to INF, timer <= max(infDur,1).
  - Otherwise stay in SUS.
- EXP: if timer==1, go to INF with timer <= max(infDur,1); otherwise timer--.
- INF:
  - If timer==1 and immDur!=0: go to REC, timer <= immDur.
  - If timer==1 and immDur==0: go to SUS.
  - Otherwise timer--.
- REC: if timer==1, go to SUS; otherwise timer--.

outputEdges:
- Updated only on step: outputEdges <= (state==INF && draw) ? connectivity : 0.
- Uses the pre-transition state.
- Holds its value between steps.
- Downstream nodes therefore see this epoch's attempts at the next step (1-epoch latency).

loadState priority:
- loadState with address match has priority over step.
- state <= initState.
- timer <= latDur for EXP, max(infDur,1) for INF, immDur for REC, 0 for SUS.
- outputEdges <= 0.
- The LFSR still advances if step is high.

Other rules:
- Duration 0 for EXP or REC means the phase is skipped. This also applies on loadState: EXP with latDur 0 moves to INF on the next step, and REC with immDur 0 moves to SUS on the next step.
- Reset asserted mid-epoch aborts immediately to the reset values; no partial config survives.
- currState = state, combinational from the register.

Decomposition:
- Shared package epidemic_pkg holds:
  - state encodings SUS/EXP/INF/REC (2 bits)
  - cfgSel codes CFG_CONN..CFG_CONN_RST
  - LFSR polynomial constant 32'h80200003
- Sub-module lfsr32_galois (clk, rst_n, advance, load, loadValue, seedParam → value). It is distinct from the existing prbs and is reused by future node types.

Test Plan:
- Connectivity load, NUM_AGENTS=40: two cfgSel 0 writes, 0xFFFF_FFFF then 0x0000_00A5. Set state INF with infThresh=0xFFFF_FFFF, then pulse step → outputEdges = 40'hA5_FFFF_FFFF. A third write wraps to word 0.
- SEIRS timing: latDur=2, infDur=3, immDur=2. Pulse neighbourEdges bit 5 on step 0 → currState sequence over steps 1..8 is EXP, EXP, INF, INF, INF, REC, REC, SUS.
- Threshold extremes: state INF with infThresh=0 for 100 steps → outputEdges always 0. With infThresh=0xFFFF_FFFF → outputEdges=connectivity on every step while INF.
- Address filtering: loadState with address=NODE_ADDR+1 and initState=INF → state unchanged. Repeat with address=NODE_ADDR → currState=INF the next cycle, outputEdges=0.
- Priority/simultaneity: loadState(SUS) and step asserted together while INF with draw=1 → state SUS, outputEdges 0. Also, cfgWrite(infDur=5) on the same step as an SUS→INF transition (latDur=0) → timer loads the old infDur.
- Reset mid-run: assert rst_n=0 asynchronously between clock edges while INF → currState=SUS and outputEdges=0 immediately. After release, infThresh=0 and the LFSR restarts at LFSR_SEED (golden sequence matches a fresh run).
